// File: rtl/operand_entry_ctrl.sv
// rtl/operand_entry_ctrl.sv - three-button operand entry FSM with debounced inputs and registered display outputs
module operand_entry_ctrl #(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_next,
    output logic [8:0] disp_value,
    output logic [1:0] mode,
    output logic       carry_led
);

    localparam int CW = $clog2(DB_CYCLES + 1);

    typedef enum logic [1:0] {
        EDIT_A   = 2'b00,
        EDIT_B   = 2'b01,
        SHOW_SUM = 2'b10
    } state_t;

    // Bit 0 = up, bit 1 = down, bit 2 = next
    logic [2:0] raw;
    logic [2:0] sync1;
    logic [2:0] sync2;
    logic [2:0] level;
    logic [2:0] level_d;
    logic [2:0] pulse;

    assign raw = {btn_next, btn_down, btn_up};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1   <= '0;
            sync2   <= '0;
            level_d <= '0;
            pulse   <= '0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_d <= level;
            pulse   <= level & ~level_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_db
            logic [CW-1:0] cnt;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt       <= '0;
                    level[gi] <= 1'b0;
                end else if (sync2[gi] == level[gi]) begin
                    cnt <= '0;
                end else if (cnt == CW'(DB_CYCLES - 1)) begin
                    cnt       <= '0;
                    level[gi] <= ~level[gi];
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    endgenerate

    logic   up_p;
    logic   down_p;
    logic   next_p;
    state_t state_q;
    state_t state_n;
    logic [7:0] a_q;
    logic [7:0] a_n;
    logic [7:0] b_q;
    logic [7:0] b_n;
    logic [8:0] sum;

    assign up_p   = pulse[0];
    assign down_p = pulse[1];
    assign next_p = pulse[2];
    assign sum    = {1'b0, a_q} + {1'b0, b_q};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EDIT_A;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_n;
            a_q     <= a_n;
            b_q     <= b_n;
        end
    end

    // next wins over up/down; up and down together cancel
    always_comb begin
        state_n = state_q;
        a_n     = a_q;
        b_n     = b_q;
        case (state_q)
            EDIT_A: begin
                if (next_p) begin
                    state_n = EDIT_B;
                end else if (up_p && !down_p) begin
                    a_n = a_q + 8'd1;
                end else if (down_p && !up_p) begin
                    a_n = a_q - 8'd1;
                end
            end
            EDIT_B: begin
                if (next_p) begin
                    state_n = SHOW_SUM;
                end else if (up_p && !down_p) begin
                    b_n = b_q + 8'd1;
                end else if (down_p && !up_p) begin
                    b_n = b_q - 8'd1;
                end
            end
            SHOW_SUM: begin
                if (next_p) begin
                    state_n = EDIT_A;
                    a_n     = '0;
                    b_n     = '0;
                end
            end
            default: begin
                state_n = EDIT_A;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp_value <= '0;
            mode       <= 2'b00;
            carry_led  <= 1'b0;
        end else begin
            mode      <= state_q;
            carry_led <= (state_q == SHOW_SUM) && sum[8];
            case (state_q)
                EDIT_A:   disp_value <= {1'b0, a_q};
                EDIT_B:   disp_value <= {1'b0, b_q};
                SHOW_SUM: disp_value <= sum;
                default:  disp_value <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_operand_entry_ctrl.sv
// tb/tb_operand_entry_ctrl.sv - directed vector bench for operand_entry_ctrl with DB_CYCLES=4
module tb_operand_entry_ctrl;

    logic       clk;
    logic       reset;
    logic       btn_up;
    logic       btn_down;
    logic       btn_next;
    logic [8:0] disp_value;
    logic [1:0] mode;
    logic       carry_led;

    int n_vec;
    int n_fail;

    operand_entry_ctrl #(.DB_CYCLES(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_next   (btn_next),
        .disp_value (disp_value),
        .mode       (mode),
        .carry_led  (carry_led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       up;
        logic       down;
        logic       nxt;
        logic [8:0] disp;
        logic [1:0] md;
        logic       carry;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input int actual, input int expected);
        n_vec++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic check_out(input string name, input int d, input int m, input int c);
        check({name, "_disp"}, int'(disp_value), d);
        check({name, "_mode"}, int'(mode), m);
        check({name, "_carry"}, int'(carry_led), c);
    endtask

    // Clean press: 10 cycles high, 10 cycles low, outputs stable afterwards
    task automatic press(input logic u, input logic d, input logic n);
        @(negedge clk);
        btn_up   = u;
        btn_down = d;
        btn_next = n;
        repeat (10) @(negedge clk);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        btn_next = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic press_n(input logic u, input logic d, input int count);
        for (int k = 0; k < count; k++) press(u, d, 1'b0);
    endtask

    // Counts edges after the first edge that samples the raw rise
    task automatic timed_up(input string name, input int expected_disp);
        logic [8:0] old;
        int         n;
        @(negedge clk);
        old    = disp_value;
        btn_up = 1'b1;
        @(posedge clk);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            n++;
            if (disp_value != old) break;
        end
        check({name, "_latency"}, n, 8);
        check({name, "_value"}, int'(disp_value), expected_disp);
        @(negedge clk);
        btn_up = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        n_vec    = 0;
        n_fail   = 0;
        reset    = 1'b1;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        btn_next = 1'b0;

        vecs[0]  = '{1'b0, 1'b1, 1'b0, 9'd3,   2'b00, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 9'd2,   2'b00, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 9'd1,   2'b00, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 9'd0,   2'b00, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 9'd255, 2'b00, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 9'd0,   2'b00, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 9'd0,   2'b00, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 9'd0,   2'b01, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 9'd1,   2'b01, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 9'd1,   2'b10, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 9'd1,   2'b10, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 9'd1,   2'b10, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 9'd0,   2'b00, 1'b0};

        repeat (3) @(negedge clk);
        check_out("in_reset", 0, 0, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_out("after_reset", 0, 0, 0);

        timed_up("up1", 1);
        timed_up("up2", 2);
        timed_up("up3", 3);
        check_out("inc3", 3, 0, 0);

        // Bounce: 3-cycle high phases never complete the debounce count
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            btn_up = 1'b1;
            repeat (3) @(negedge clk);
            btn_up = 1'b0;
            repeat (2) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        check_out("bounce_none", 3, 0, 0);
        btn_up = 1'b1;
        repeat (10) @(negedge clk);
        btn_up = 1'b0;
        repeat (12) @(negedge clk);
        check_out("bounce_one", 4, 0, 0);

        for (int i = 0; i < 13; i++) begin
            press(vecs[i].up, vecs[i].down, vecs[i].nxt);
            check_out($sformatf("vec%0d", i), int'(vecs[i].disp), int'(vecs[i].md), int'(vecs[i].carry));
        end

        press_n(1'b0, 1'b1, 56);
        check_out("a200", 200, 0, 0);
        press(1'b0, 1'b0, 1'b1);
        press_n(1'b0, 1'b1, 156);
        check_out("b100", 100, 1, 0);
        press(1'b0, 1'b0, 1'b1);
        check_out("sum300", 300, 2, 1);
        press(1'b0, 1'b0, 1'b1);
        check_out("sum_clear", 0, 0, 0);

        press_n(1'b1, 1'b0, 5);
        check_out("a5", 5, 0, 0);
        press(1'b1, 1'b0, 1'b1);
        check_out("prio_next", 0, 1, 0);
        press(1'b0, 1'b0, 1'b1);
        check_out("prio_a_kept", 5, 2, 0);
        press(1'b0, 1'b0, 1'b1);

        press(1'b0, 1'b0, 1'b1);
        press_n(1'b1, 1'b0, 7);
        check_out("b7", 7, 1, 0);
        @(negedge clk);
        btn_up = 1'b1;
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_out("async_reset", 0, 0, 0);
        btn_up = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check_out("no_pulse_after_reset", 0, 0, 0);

        // Button held through reset release yields one pulse
        reset  = 1'b1;
        btn_up = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        begin
            int n;
            n = 0;
            for (int k = 0; k < 20; k++) begin
                @(posedge clk);
                #1;
                n++;
                if (disp_value != 9'd0) break;
            end
            check("held_reset_latency", n, 9);
        end
        repeat (20) @(negedge clk);
        check_out("held_single_pulse", 1, 0, 0);
        btn_up = 1'b0;
        repeat (12) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
